sle_sipo_collector: RTL and testbench

- Downstream consumer of the single-bit SLE register output (q).
- Collects qualified serial bits into WIDTH-bit words and presents them through a one-entry output buffer with a valid/ready handshake.
- Backpressures the bit source with in_ready when that buffer is full.
- Supports a synchronous active-low clear in the same style as the SLE sync-load control.

---
 rtl/sle_sipo_if.sv | 31 +++
 rtl/sle_sipo_collector.sv | 81 ++++++++
 tb/tb_sle_sipo_collector.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sle_sipo_if.sv
// Bit-stream and word-buffer signals between the SLE bit source, the
// SIPO collector and the word consumer.
interface sle_sipo_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  localparam int BW = $clog2(WIDTH);

  // Handshake: a bit transfers on a rising edge where en & in_ready are both
  // high; a word transfers on a rising edge where dout_valid & out_ready are
  // both high. in_ready may depend combinationally on out_ready; dout and
  // dout_valid never change while dout_valid=1 and out_ready=0.
  logic             din;
  logic             en;
  logic             in_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             out_ready;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] word_cnt;

  modport slave (
    input  din, en, out_ready,
    output in_ready, dout, dout_valid, bit_cnt, word_cnt
  );

  modport master (
    output din, en, out_ready,
    input  in_ready, dout, dout_valid, bit_cnt, word_cnt
  );
endinterface

// File: rtl/sle_sipo_collector.sv
// Serial-in parallel-out collector for the SLE q bit: assembles WIDTH-bit
// words into a one-entry output buffer with valid/ready flow control.
module sle_sipo_collector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input logic      clk,
  input logic      aln,
  input logic      sln,
  sle_sipo_if.slave bus
);
  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic [BW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_at_last;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_consume;
  logic [WIDTH-1:0] w_sreg_next;

  // Only the word-completing bit has to wait for the buffer; partial bits
  // keep flowing into the shift register while the consumer stalls.
  assign w_at_last  = (r_bit_cnt == LAST_IDX);
  assign w_in_ready = ~(r_dout_valid & ~bus.out_ready & w_at_last);
  assign w_accept   = bus.en & w_in_ready;
  assign w_last     = w_accept & w_at_last;
  assign w_consume  = r_dout_valid & bus.out_ready;

  always_comb begin
    w_sreg_next = r_sreg;
    if (MSB_FIRST) begin
      w_sreg_next = {r_sreg[WIDTH-2:0], bus.din};
    end else begin
      w_sreg_next = {bus.din, r_sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge aln) begin
    if (!aln) begin
      r_sreg       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
    end else if (!sln) begin
      // Clear drops buffered and partial data but keeps the delivery count.
      r_sreg       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_bit_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_sreg    <= w_sreg_next;
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + BW'(1);
      end
      if (w_last) begin
        r_dout       <= w_sreg_next;
        r_dout_valid <= 1'b1;
      end else if (w_consume) begin
        r_dout_valid <= 1'b0;
      end
      if (w_consume) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.bit_cnt    = r_bit_cnt;
  assign bus.word_cnt   = r_word_cnt;
endmodule

// File: tb/tb_sle_sipo_collector.sv
// Directed bench for sle_sipo_collector: MSB-first, LSB-first and 2-bit
// word counter variants driven with one shared stimulus stream.
module tb_sle_sipo_collector;
  logic clk;
  logic aln;
  logic sln;
  logic din;
  logic en;
  logic out_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];

  sle_sipo_if #(.WIDTH(8), .CNT_W(8)) if_a ();
  sle_sipo_if #(.WIDTH(8), .CNT_W(8)) if_b ();
  sle_sipo_if #(.WIDTH(8), .CNT_W(2)) if_c ();

  assign if_a.din = din;  assign if_a.en = en;  assign if_a.out_ready = out_ready;
  assign if_b.din = din;  assign if_b.en = en;  assign if_b.out_ready = out_ready;
  assign if_c.din = din;  assign if_c.en = en;  assign if_c.out_ready = out_ready;

  sle_sipo_collector #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .aln(aln), .sln(sln), .bus(if_a)
  );
  sle_sipo_collector #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .aln(aln), .sln(sln), .bus(if_b)
  );
  sle_sipo_collector #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .aln(aln), .sln(sln), .bus(if_c)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic b);
    din = b;
    en  = 1'b1;
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      din = w[i];
      en  = 1'b1;
      tick();
    end
    en = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout_a"}, if_a.dout, 8'h00);
    chk({tag, "_dout_b"}, if_b.dout, 8'h00);
    chk({tag, "_valid"}, if_a.dout_valid, 1'b0);
    chk({tag, "_bitcnt"}, if_a.bit_cnt, 3'd0);
    chk({tag, "_wcnt_a"}, if_a.word_cnt, 8'd0);
    chk({tag, "_wcnt_c"}, if_c.word_cnt, 2'd0);
    chk({tag, "_in_ready"}, if_a.in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] m_word;
    logic [2:0] m_cnt;
    logic       m_valid;
    int         m_wcnt;
    int         pushed;
    logic       exp_ir;
    logic       consume;
    logic       acc;
    logic       done;
    logic [7:0] head;

    aln = 1'b0; sln = 1'b1; din = 1'b0; en = 1'b0; out_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      din = 1'($urandom_range(0, 1));
      en = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      chk_zero("reset");
    end
    aln = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_zero("idle");

    // Basic word, MSB-first and LSB-first
    out_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      din = i[0] ? 1'b0 : 1'b0;
      din = (8'hB2 >> i) & 8'h01;
      en = 1'b1;
      tick();
      if (i == 5) chk("basic_bitcnt3", if_a.bit_cnt, 3'd3);
    end
    en = 1'b0;
    chk("basic_valid", if_a.dout_valid, 1'b1);
    chk("basic_dout_a", if_a.dout, 8'hB2);
    chk("basic_dout_b", if_b.dout, 8'h4D);
    chk("basic_bitcnt0", if_a.bit_cnt, 3'd0);
    chk("basic_wcnt_pre", if_a.word_cnt, 8'd0);
    tick();
    chk("basic_consumed", if_a.dout_valid, 1'b0);
    chk("basic_wcnt", if_a.word_cnt, 8'd1);
    chk("basic_dout_hold", if_a.dout, 8'hB2);

    // Backpressure: second word stalls on its last bit, then loads on consume
    out_ready = 1'b0;
    send_word(8'hB2);
    chk("bp_valid1", if_a.dout_valid, 1'b1);
    chk("bp_dout1", if_a.dout, 8'hB2);
    for (int i = 7; i >= 1; i--) begin
      present((8'h96 >> i) & 8'h01);
      chk("bp_partial_ready", if_a.in_ready, 1'b1);
      tick();
    end
    chk("bp_bitcnt7", if_a.bit_cnt, 3'd7);
    present(1'b0);
    chk("bp_stall_ready", if_a.in_ready, 1'b0);
    tick();
    chk("bp_stall_bitcnt", if_a.bit_cnt, 3'd7);
    chk("bp_stall_dout", if_a.dout, 8'hB2);
    chk("bp_stall_valid", if_a.dout_valid, 1'b1);
    chk("bp_stall_wcnt", if_a.word_cnt, 8'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", if_a.in_ready, 1'b1);
    tick();
    en = 1'b0;
    chk("bp_b2b_valid", if_a.dout_valid, 1'b1);
    chk("bp_b2b_dout_a", if_a.dout, 8'h96);
    chk("bp_b2b_dout_b", if_b.dout, 8'h69);
    chk("bp_b2b_bitcnt", if_a.bit_cnt, 3'd0);
    chk("bp_b2b_wcnt", if_a.word_cnt, 8'd2);
    tick();
    chk("bp_drain_valid", if_a.dout_valid, 1'b0);
    chk("bp_drain_wcnt", if_a.word_cnt, 8'd3);

    // Sync clear with a buffered word and a partial word
    out_ready = 1'b0;
    send_word(8'hA5);
    chk("sc_valid_pre", if_a.dout_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      din = 1'(i[0]);
      en = 1'b1;
      tick();
    end
    chk("sc_bitcnt5", if_a.bit_cnt, 3'd5);
    sln = 1'b0; din = 1'b1; en = 1'b1;
    tick();
    chk("sc_bitcnt", if_a.bit_cnt, 3'd0);
    chk("sc_valid", if_a.dout_valid, 1'b0);
    chk("sc_dout", if_a.dout, 8'h00);
    chk("sc_wcnt", if_a.word_cnt, 8'd3);
    sln = 1'b1; en = 1'b0; out_ready = 1'b1;
    send_word(8'h3E);
    chk("sc_word_valid", if_a.dout_valid, 1'b1);
    chk("sc_word_dout_a", if_a.dout, 8'h3E);
    chk("sc_word_dout_b", if_b.dout, 8'h7C);
    tick();
    chk("sc_word_wcnt", if_a.word_cnt, 8'd4);
    chk("sc_word_wcnt_c", if_c.word_cnt, 2'd0);

    // Random gaps and stalls against a reference model, 50 words
    m_word = 8'h00; m_cnt = 3'd0; m_valid = 1'b0; m_wcnt = 4; pushed = 0; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      en = (pushed < 50) ? ($urandom_range(0, 3) != 0) : 1'b0;
      din = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_ir = !(m_valid && !out_ready && m_cnt == 3'd7);
      chk("rnd_in_ready", if_a.in_ready, exp_ir);
      consume = m_valid & out_ready;
      if (consume) begin
        if (exp_q.size() == 0) begin
          chk("rnd_queue_underflow", 32'd0, 32'd1);
        end else begin
          head = exp_q.pop_front();
          chk("rnd_dout_a", if_a.dout, head);
          chk("rnd_dout_b", if_b.dout, rev8(head));
        end
        m_wcnt++;
      end
      acc = en & exp_ir;
      if (acc) begin
        m_word = {m_word[6:0], din};
        if (m_cnt == 3'd7) begin
          exp_q.push_back(m_word);
          pushed++;
          m_cnt = 3'd0;
          m_valid = 1'b1;
        end else begin
          m_cnt = m_cnt + 3'd1;
          if (consume) m_valid = 1'b0;
        end
      end else if (consume) begin
        m_valid = 1'b0;
      end
      tick();
      chk("rnd_valid", if_a.dout_valid, m_valid);
      chk("rnd_bitcnt", if_a.bit_cnt, m_cnt);
      chk("rnd_wcnt_a", if_a.word_cnt, 32'(m_wcnt) & 32'hFF);
      chk("rnd_wcnt_c", if_c.word_cnt, 32'(m_wcnt) & 32'h3);
      if (m_wcnt == 5) chk("wrap_five_words", if_c.word_cnt, 2'd1);
      if (pushed >= 50 && !m_valid) done = 1'b1;
    end
    en = 1'b0;
    chk("rnd_done", done, 1'b1);
    chk("rnd_queue_empty", exp_q.size(), 32'd0);
    chk("rnd_wcnt_final", if_a.word_cnt, 8'd54);
    chk("rnd_wcnt_c_final", if_c.word_cnt, 2'd2);

    // Asynchronous abort with a buffered word and a partial word
    out_ready = 1'b0;
    send_word(8'hC3);
    chk("ab_valid_pre", if_a.dout_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      din = 1'b1;
      en = 1'b1;
      tick();
    end
    chk("ab_bitcnt3", if_a.bit_cnt, 3'd3);
    #3;
    aln = 1'b0;
    #1;
    chk_zero("abort");
    tick();
    aln = 1'b1; en = 1'b0;
    tick();
    tick();
    chk("ab_after_valid", if_a.dout_valid, 1'b0);
    chk("ab_after_dout", if_a.dout, 8'h00);
    out_ready = 1'b1;
    send_word(8'h5A);
    chk("ab_recover_dout", if_a.dout, 8'h5A);
    chk("ab_recover_valid", if_a.dout_valid, 1'b1);
    tick();
    chk("ab_recover_wcnt", if_a.word_cnt, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
